// File: rtl/rv_pkg.sv
// Shared types and RISC-V SYSTEM-opcode constants for the test-end monitor.
package rv_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DUMP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0]  OPCODE_SYSTEM  = 7'b1110011;
  localparam logic [2:0]  FUNCT3_PRIV    = 3'b000;
  localparam logic [11:0] FUNCT12_ECALL  = 12'h000;
  localparam logic [11:0] FUNCT12_EBREAK = 12'h001;

endpackage

// File: rtl/rv_sys_decode.sv
// Combinational detect of a retiring ECALL/EBREAK that ends the test program.
module rv_sys_decode
  import rv_pkg::*;
(
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        trigger
);

  logic is_env;
  logic unused_fields;

  // rs1/rd are not part of the end-of-test match
  assign unused_fields = ^{inst[19:15], inst[11:7]};

  always_comb begin
    is_env  = (inst[31:20] == FUNCT12_ECALL) || (inst[31:20] == FUNCT12_EBREAK);
    trigger = inst_valid && (inst[6:0] == OPCODE_SYSTEM) &&
              (inst[14:12] == FUNCT3_PRIV) && is_env;
  end

endmodule

// File: rtl/rv_test_monitor.sv
// End-of-test monitor: on ECALL/EBREAK or timeout, dumps the register file
// through the debug read port and reports the verdict held in x[PASS_REG].
//
// state | meaning
// RUN   | program running, cycle counter active, waiting for trigger/timeout
// DUMP  | stepping debug read address; strobes trail reads by one cycle
// CHECK | last strobe seen, verdict computed from captured result
// DONE  | verdict outputs held until reset
module rv_test_monitor
  import rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int PASS_REG = 3,
  parameter int TIMEOUT  = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_valid,
  input  logic [31:0]              inst,
  output logic [$clog2(NREGS)-1:0] rf_raddr,
  input  logic [XLEN-1:0]          rf_rdata,
  output logic                     dump_valid,
  output logic [$clog2(NREGS)-1:0] dump_idx,
  output logic [XLEN-1:0]          dump_data,
  output logic                     done,
  output logic                     pass,
  output logic [XLEN-1:0]          fail_test,
  output logic                     timed_out
);

  localparam int              AW      = $clog2(NREGS);
  localparam logic [AW:0]     LAST_RD = (AW+1)'(NREGS);
  localparam logic [AW-1:0]   RES_IDX = AW'(PASS_REG);
  localparam logic [31:0]     TMO     = 32'(TIMEOUT);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);

  state_t          state, state_nxt;
  logic            trigger;
  logic            tmo_hit;
  logic            reading;
  logic [31:0]     cnt;
  logic [AW:0]     rd_cnt;
  logic [XLEN-1:0] result;
  logic            dump_valid_q;
  logic [AW-1:0]   dump_idx_q;

  rv_sys_decode u_sys_decode (
    .inst_valid (inst_valid),
    .inst       (inst),
    .trigger    (trigger)
  );

  assign tmo_hit = (TMO != 32'd0) && (cnt == TMO - 32'd1);
  assign reading = (state == DUMP) && (rd_cnt != LAST_RD);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trigger || tmo_hit) state_nxt = DUMP;
      DUMP:    if (rd_cnt == LAST_RD) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      rd_cnt       <= '0;
      result       <= '0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_test    <= '0;
      timed_out    <= 1'b0;
    end else begin
      dump_valid_q <= reading;
      dump_idx_q   <= reading ? rd_cnt[AW-1:0] : '0;

      if (state == RUN) begin
        if (cnt != TMO) cnt <= cnt + 32'd1;
        // trigger beats a coincident timeout
        if (!trigger && tmo_hit) timed_out <= 1'b1;
      end

      if (reading) rd_cnt <= rd_cnt + (AW+1)'(1);
      else if (state != DUMP) rd_cnt <= '0;

      if (dump_valid_q && (dump_idx_q == RES_IDX)) result <= rf_rdata;

      if (state == CHECK) begin
        done      <= 1'b1;
        pass      <= (result == ONE);
        fail_test <= result >> 1;
      end
    end
  end

  assign rf_raddr   = reading ? rd_cnt[AW-1:0] : '0;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  // read data arrives one cycle after the address, aligned with the strobe
  assign dump_data  = dump_valid_q ? rf_rdata : '0;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Randomized bench for rv_test_monitor: two instances (32x32 and 16x64) share
// stimulus; expectations come from a cycle-level model of the test-end rules.
module tb_rv_test_monitor;

  localparam int TO = 50;
  localparam int NA = 32;
  localparam int NB = 16;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;

  logic [4:0]  raddr_a, idx_a;
  logic [31:0] rdata_a, data_a, fail_a;
  logic        dv_a, done_a, pass_a, to_a;
  logic [3:0]  raddr_b, idx_b;
  logic [63:0] rdata_b, data_b, fail_b;
  logic        dv_b, done_b, pass_b, to_b;

  logic [31:0] regs_a [NA];
  logic [63:0] regs_b [NB];

  int n_chk = 0;
  int n_pass = 0;
  int strobes_a, strobes_b, first_dv_a, done_cyc_a;

  rv_test_monitor #(.XLEN(32), .NREGS(NA), .PASS_REG(3), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .rf_raddr(raddr_a), .rf_rdata(rdata_a), .dump_valid(dv_a), .dump_idx(idx_a),
    .dump_data(data_a), .done(done_a), .pass(pass_a), .fail_test(fail_a),
    .timed_out(to_a)
  );

  rv_test_monitor #(.XLEN(64), .NREGS(NB), .PASS_REG(3), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .rf_raddr(raddr_b), .rf_rdata(rdata_b), .dump_valid(dv_b), .dump_idx(idx_b),
    .dump_data(data_b), .done(done_b), .pass(pass_b), .fail_test(fail_b),
    .timed_out(to_b)
  );

  always #5 clk = ~clk;

  // register files with one-cycle read latency
  always @(posedge clk) begin
    rdata_a <= regs_a[raddr_a];
    rdata_b <= regs_b[raddr_b];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_trig(input logic v, input logic [31:0] w);
    return v && (w[6:0] == 7'h73) && (w[14:12] == 3'd0) &&
           (w[31:20] == 12'd0 || w[31:20] == 12'd1);
  endfunction

  function automatic logic [31:0] near_miss();
    logic [31:0] w;
    case ($urandom_range(0, 4))
      0: w = 32'h00200073;
      1: w = 32'h00001073;
      2: w = 32'h30200073;
      3: w = 32'h00102073;
      default: begin
        w = $urandom;
        if (w[6:0] == 7'h73) w[0] = 1'b0;
      end
    endcase
    return w;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_dv_a"}, dv_a, 0);     chk({tag, "_idx_a"}, idx_a, 0);
    chk({tag, "_data_a"}, data_a, 0); chk({tag, "_done_a"}, done_a, 0);
    chk({tag, "_pass_a"}, pass_a, 0); chk({tag, "_fail_a"}, fail_a, 0);
    chk({tag, "_to_a"}, to_a, 0);     chk({tag, "_raddr_a"}, raddr_a, 0);
    chk({tag, "_dv_b"}, dv_b, 0);     chk({tag, "_done_b"}, done_b, 0);
    chk({tag, "_fail_b"}, fail_b, 0); chk({tag, "_raddr_b"}, raddr_b, 0);
  endtask

  // expected outputs at cycle n, where e is the cycle whose edge entered the dump
  task automatic check_outs(input int n, input int e, input bit tof);
    int rel;
    bit s, d;
    rel = (e >= 0) ? n - e : -1;
    if (dv_a) strobes_a++;
    if (dv_b) strobes_b++;
    if (dv_a && first_dv_a < 0) first_dv_a = n;
    if (done_a && done_cyc_a < 0) done_cyc_a = n;

    s = (e >= 0) && rel >= 1 && rel <= NA;
    d = (e >= 0) && rel >= NA + 2;
    chk($sformatf("a_valid@%0d", n), dv_a, s);
    chk($sformatf("a_idx@%0d", n), idx_a, s ? rel - 1 : 0);
    chk($sformatf("a_data@%0d", n), data_a, s ? regs_a[rel-1] : 0);
    chk($sformatf("a_raddr@%0d", n), raddr_a, (e >= 0 && rel >= 0 && rel < NA) ? rel : 0);
    chk($sformatf("a_done@%0d", n), done_a, d);
    if (d) begin
      chk($sformatf("a_pass@%0d", n), pass_a, regs_a[3] == 32'd1);
      chk($sformatf("a_fail@%0d", n), fail_a, regs_a[3] >> 1);
      chk($sformatf("a_to@%0d", n), to_a, tof);
    end

    s = (e >= 0) && rel >= 1 && rel <= NB;
    d = (e >= 0) && rel >= NB + 2;
    chk($sformatf("b_valid@%0d", n), dv_b, s);
    chk($sformatf("b_idx@%0d", n), idx_b, s ? rel - 1 : 0);
    chk($sformatf("b_data@%0d", n), data_b, s ? regs_b[rel-1] : 0);
    chk($sformatf("b_raddr@%0d", n), raddr_b, (e >= 0 && rel >= 0 && rel < NB) ? rel : 0);
    chk($sformatf("b_done@%0d", n), done_b, d);
    if (d) begin
      chk($sformatf("b_pass@%0d", n), pass_b, regs_b[3] == 64'd1);
      chk($sformatf("b_fail@%0d", n), fail_b, regs_b[3] >> 1);
      chk($sformatf("b_to@%0d", n), to_b, tof);
    end
  endtask

  // cycle 0 is the last reset edge; t<0 means no deliberate trigger
  task automatic run_case(input int t, input logic [31:0] tw, input logic [31:0] x3a,
                          input logic [63:0] x3b, input int rst_at, input bit do_reset);
    int e, n;
    bit tof;
    for (int i = 0; i < NA; i++) regs_a[i] = $urandom;
    for (int i = 0; i < NB; i++) regs_b[i] = {$urandom, $urandom};
    regs_a[3] = x3a;
    regs_b[3] = x3b;
    e = -1; tof = 1'b0;
    strobes_a = 0; strobes_b = 0; first_dv_a = -1; done_cyc_a = -1;
    if (do_reset) begin
      rst = 1'b1; inst_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset("rst");
    end
    rst = 1'b0;
    n = 0;
    while (n < 200) begin
      n++;
      if (n == t) begin inst = tw; inst_valid = 1'b1; end
      else if (e >= 0) begin inst = ECALL; inst_valid = 1'($urandom_range(0, 1)); end
      else if (n == 5) begin inst = 32'h00200073; inst_valid = 1'b1; end
      else if (n == 6) begin inst = 32'h00001073; inst_valid = 1'b1; end
      else if (n == 7) begin inst = ECALL; inst_valid = 1'b0; end
      else begin inst = near_miss(); inst_valid = 1'($urandom_range(0, 1)); end
      if (e < 0) begin
        if (is_trig(inst_valid, inst)) begin e = n; tof = 1'b0; end
        else if (n == TO) begin e = n; tof = 1'b1; end
      end
      @(posedge clk);
      #1 check_outs(n, e, tof);
      if (rst_at >= 0 && e >= 0 && n == e + rst_at) begin
        rst = 1'b1; inst_valid = 1'b0;
        @(posedge clk);
        #1 check_reset("midrst");
        return;
      end
      if (e >= 0 && n >= e + NA + 4) break;
    end
  endtask

  initial begin
    for (int i = 0; i < NA; i++) regs_a[i] = '0;
    for (int i = 0; i < NB; i++) regs_b[i] = '0;

    run_case(10, ECALL, 32'd1, 64'd1, -1, 1'b1);
    chk("c1_done_cycle", done_cyc_a, 44);
    chk("c1_pass", pass_a, 1);
    chk("c1_fail", fail_a, 0);
    chk("c1_to", to_a, 0);
    chk("c1_strobes_a", strobes_a, NA);
    chk("c1_strobes_b", strobes_b, NB);

    run_case(20, EBREAK, 32'd7, 64'd7, -1, 1'b1);
    chk("c2_pass", pass_a, 0);
    chk("c2_fail", fail_a, 3);
    chk("c2_fail_b", fail_b, 3);

    run_case(-1, ECALL, $urandom, {$urandom, $urandom}, -1, 1'b1);
    chk("c3_to", to_a, 1);
    chk("c3_to_b", to_b, 1);
    chk("c3_first_strobe", first_dv_a, TO + 1);

    run_case(TO, ECALL, 32'd1, 64'd1, -1, 1'b1);
    chk("c4_to", to_a, 0);
    chk("c4_pass", pass_a, 1);

    run_case(12, ECALL, 32'd1, 64'd1, 5, 1'b1);
    chk("c5_strobes_before_rst", strobes_a, 5);

    run_case(8, ECALL, 32'd1, 64'h8000_0000_0000_0003, -1, 1'b0);
    chk("c6_strobes_a", strobes_a, NA);
    chk("c6_strobes_b", strobes_b, NB);
    chk("c6_fail_b", fail_b, 64'h4000_0000_0000_0001);

    repeat (6) begin
      run_case(int'($urandom_range(1, 60)), ($urandom_range(0, 1) != 0) ? ECALL : EBREAK,
               ($urandom_range(0, 1) != 0) ? 32'd1 : $urandom,
               ($urandom_range(0, 1) != 0) ? 64'd1 : {$urandom, $urandom}, -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
